ctrl_pipeline: RTL and testbench

Pipelined main-control unit for the 5-stage MIPS core. It decodes the ID-stage instruction into a control bundle and carries that bundle through registered ID/EX, EX/MEM and MEM/WB stages. It also detects load-use hazards, inserts bubbles, honours branch/jump flushes and global stalls, and keeps a saturating count of illegal opcodes. It sits between the instruction register and the datapath muxes, and it fully replaces the combinational opcode decoder.

---
 rtl/ctrl_pipeline.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipeline
//  Description : Pipelined main-control unit for the 5-stage MIPS core.
//                Decodes the ID-stage instruction into a control bundle and
//                carries it through registered ID/EX, EX/MEM and MEM/WB
//                stages. Detects load-use hazards (bubble insertion), honours
//                branch/jump flushes and global memory stalls, and keeps a
//                saturating count of illegal opcodes.
//  Ports       :
//    clk            in   rising-edge clock
//    rst_n          in   asynchronous active-low reset
//    i_id_valid     in   ID stage holds a real instruction
//    i_id_instr     in   ID-stage instruction word (32)
//    i_flush        in   branch/jump taken, kill the ID instruction
//    i_stall_ext    in   memory stall, freeze all stage registers
//    o_hazard_stall out  combinational load-use stall request to IF/ID
//    o_ex_*         out  EX-stage controls (valid, alu_src, sign_ext,
//                        branch, bne, jump, alu_op, dest)
//    o_mem_*        out  MEM-stage controls (valid, read, write, dest)
//    o_wb_*         out  WB-stage controls (valid, reg_write, mem_to_reg,
//                        link, dest)
//    o_illegal_cnt  out  saturating count of retired illegal opcodes
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_pipeline #(
   parameter int REG_AW  = 5,
   parameter int ALUOP_W = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_id_valid,
   input  logic [31:0]        i_id_instr,
   input  logic               i_flush,
   input  logic               i_stall_ext,
   output logic               o_hazard_stall,
   output logic               o_ex_valid,
   output logic               o_ex_alu_src,
   output logic               o_ex_sign_ext,
   output logic               o_ex_branch,
   output logic               o_ex_bne,
   output logic               o_ex_jump,
   output logic [ALUOP_W-1:0] o_ex_alu_op,
   output logic [REG_AW-1:0]  o_ex_dest,
   output logic               o_mem_valid,
   output logic               o_mem_read,
   output logic               o_mem_write,
   output logic [REG_AW-1:0]  o_mem_dest,
   output logic               o_wb_valid,
   output logic               o_wb_reg_write,
   output logic               o_wb_mem_to_reg,
   output logic               o_wb_link,
   output logic [REG_AW-1:0]  o_wb_dest,
   output logic [CNT_W-1:0]   o_illegal_cnt
);

   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_J     = 6'b000010;
   localparam logic [5:0] c_OP_JAL   = 6'b000011;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_BNE   = 6'b000101;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_ADDIU = 6'b001001;
   localparam logic [5:0] c_OP_ANDI  = 6'b001100;
   localparam logic [5:0] c_OP_ORI   = 6'b001101;
   localparam logic [5:0] c_OP_XORI  = 6'b001110;
   localparam logic [5:0] c_OP_LUI   = 6'b001111;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;

   // Full bundle held in ID/EX; later stages keep only what they still need.
   typedef struct packed {
      logic               valid;
      logic               alu_src;
      logic               sign_ext;
      logic               branch;
      logic               bne;
      logic               jump;
      logic [ALUOP_W-1:0] alu_op;
      logic [REG_AW-1:0]  dest;
      logic               mem_read;
      logic               mem_write;
      logic               reg_write;
      logic               mem_to_reg;
      logic               link;
   } ex_ctrl_t;

   typedef struct packed {
      logic               valid;
      logic               mem_read;
      logic               mem_write;
      logic [REG_AW-1:0]  dest;
      logic               reg_write;
      logic               mem_to_reg;
      logic               link;
   } mem_ctrl_t;

   typedef struct packed {
      logic               valid;
      logic               reg_write;
      logic               mem_to_reg;
      logic               link;
      logic [REG_AW-1:0]  dest;
   } wb_ctrl_t;

   logic [5:0] w_op;
   logic [4:0] w_rs;
   logic [4:0] w_rt;
   logic [4:0] w_rd;
   logic       w_unused_instr_bits;

   assign w_op = i_id_instr[31:26];
   assign w_rs = i_id_instr[25:21];
   assign w_rt = i_id_instr[20:16];
   assign w_rd = i_id_instr[15:11];
   assign w_unused_instr_bits = ^i_id_instr[10:0];

   ex_ctrl_t   w_dec;
   ex_ctrl_t   w_ex_next;
   logic       w_legal;
   logic       w_uses_rs;
   logic       w_uses_rt;
   logic       w_fire;
   logic       w_rs_hit;
   logic       w_rt_hit;
   logic       w_hazard;
   logic       w_cnt_inc;

   ex_ctrl_t   r_ex;
   mem_ctrl_t  r_mem;
   wb_ctrl_t   r_wb;
   logic [CNT_W-1:0] r_illegal_cnt;

   // ---------------------------------------------------------------------
   // Opcode decode
   // ---------------------------------------------------------------------
   always_comb begin
      w_dec     = '0;
      w_legal   = 1'b1;
      w_uses_rs = 1'b1;
      w_uses_rt = 1'b0;
      case (w_op)
         c_OP_RTYPE: begin
            w_dec.alu_op    = ALUOP_W'(4'b1000);
            w_dec.dest      = REG_AW'(w_rd);
            w_dec.reg_write = 1'b1;
            w_uses_rt       = 1'b1;
         end
         c_OP_LW: begin
            w_dec.alu_src    = 1'b1;
            w_dec.mem_read   = 1'b1;
            w_dec.mem_to_reg = 1'b1;
            w_dec.dest       = REG_AW'(w_rt);
            w_dec.reg_write  = 1'b1;
         end
         c_OP_SW: begin
            w_dec.alu_src   = 1'b1;
            w_dec.mem_write = 1'b1;
            w_uses_rt       = 1'b1;
         end
         c_OP_BEQ: begin
            w_dec.alu_op = ALUOP_W'(4'b0100);
            w_dec.branch = 1'b1;
            w_uses_rt    = 1'b1;
         end
         c_OP_BNE: begin
            w_dec.alu_op = ALUOP_W'(4'b0110);
            w_dec.branch = 1'b1;
            w_dec.bne    = 1'b1;
            w_uses_rt    = 1'b1;
         end
         c_OP_ADDI, c_OP_ADDIU: begin
            w_dec.alu_op    = ALUOP_W'(4'b0001);
            w_dec.alu_src   = 1'b1;
            w_dec.sign_ext  = 1'b1;
            w_dec.dest      = REG_AW'(w_rt);
            w_dec.reg_write = 1'b1;
         end
         c_OP_ANDI: begin
            w_dec.alu_op    = ALUOP_W'(4'b0010);
            w_dec.alu_src   = 1'b1;
            w_dec.dest      = REG_AW'(w_rt);
            w_dec.reg_write = 1'b1;
         end
         c_OP_ORI: begin
            w_dec.alu_op    = ALUOP_W'(4'b0011);
            w_dec.alu_src   = 1'b1;
            w_dec.dest      = REG_AW'(w_rt);
            w_dec.reg_write = 1'b1;
         end
         c_OP_XORI: begin
            w_dec.alu_op    = ALUOP_W'(4'b0101);
            w_dec.alu_src   = 1'b1;
            w_dec.dest      = REG_AW'(w_rt);
            w_dec.reg_write = 1'b1;
         end
         c_OP_LUI: begin
            w_dec.alu_op    = ALUOP_W'(4'b0111);
            w_dec.alu_src   = 1'b1;
            w_dec.dest      = REG_AW'(w_rt);
            w_dec.reg_write = 1'b1;
         end
         c_OP_J: begin
            w_dec.jump = 1'b1;
            w_uses_rs  = 1'b0;
         end
         c_OP_JAL: begin
            w_dec.jump      = 1'b1;
            w_dec.link      = 1'b1;
            w_dec.dest      = REG_AW'(31);
            w_dec.reg_write = 1'b1;
            w_uses_rs       = 1'b0;
         end
         default: begin
            w_legal = 1'b0;
         end
      endcase
      // Writes to $0 are architecturally discarded; kill them here so the
      // forwarding/writeback logic never sees a live write to register 0.
      if (w_dec.dest == '0) begin
         w_dec.reg_write = 1'b0;
      end
      w_dec.valid = 1'b1;
   end

   // Only legal, valid instructions enter EX; everything else is a bubble.
   assign w_fire    = i_id_valid && w_legal;
   assign w_ex_next = w_fire ? w_dec : '0;

   // ---------------------------------------------------------------------
   // Load-use hazard: the load in EX has not produced its data yet.
   // ---------------------------------------------------------------------
   assign w_rs_hit = w_uses_rs && (r_ex.dest == REG_AW'(w_rs));
   assign w_rt_hit = w_uses_rt && (r_ex.dest == REG_AW'(w_rt));
   assign w_hazard = r_ex.valid && r_ex.mem_read && (r_ex.dest != '0) &&
                     i_id_valid && (w_rs_hit || w_rt_hit);

   assign o_hazard_stall = w_hazard;

   // An illegal opcode is counted only when it actually leaves ID.
   assign w_cnt_inc = i_id_valid && !w_legal && !i_stall_ext && !i_flush &&
                      !w_hazard && (r_illegal_cnt != '1);

   // ---------------------------------------------------------------------
   // Stage registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex          <= '0;
         r_mem         <= '0;
         r_wb          <= '0;
         r_illegal_cnt <= '0;
      end else if (!i_stall_ext) begin
         if (i_flush || w_hazard) begin
            r_ex <= '0;
         end else begin
            r_ex <= w_ex_next;
         end
         r_mem.valid      <= r_ex.valid;
         r_mem.mem_read   <= r_ex.mem_read;
         r_mem.mem_write  <= r_ex.mem_write;
         r_mem.dest       <= r_ex.dest;
         r_mem.reg_write  <= r_ex.reg_write;
         r_mem.mem_to_reg <= r_ex.mem_to_reg;
         r_mem.link       <= r_ex.link;
         r_wb.valid       <= r_mem.valid;
         r_wb.reg_write   <= r_mem.reg_write;
         r_wb.mem_to_reg  <= r_mem.mem_to_reg;
         r_wb.link        <= r_mem.link;
         r_wb.dest        <= r_mem.dest;
         if (w_cnt_inc) begin
            r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
         end
      end
   end

   assign o_ex_valid      = r_ex.valid;
   assign o_ex_alu_src    = r_ex.alu_src;
   assign o_ex_sign_ext   = r_ex.sign_ext;
   assign o_ex_branch     = r_ex.branch;
   assign o_ex_bne        = r_ex.bne;
   assign o_ex_jump       = r_ex.jump;
   assign o_ex_alu_op     = r_ex.alu_op;
   assign o_ex_dest       = r_ex.dest;
   assign o_mem_valid     = r_mem.valid;
   assign o_mem_read      = r_mem.mem_read;
   assign o_mem_write     = r_mem.mem_write;
   assign o_mem_dest      = r_mem.dest;
   assign o_wb_valid      = r_wb.valid;
   assign o_wb_reg_write  = r_wb.reg_write;
   assign o_wb_mem_to_reg = r_wb.mem_to_reg;
   assign o_wb_link       = r_wb.link;
   assign o_wb_dest       = r_wb.dest;
   assign o_illegal_cnt   = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_pipeline
//  Description : Self-checking bench for ctrl_pipeline. A decode table is
//                streamed through the pipe and checked at EX, MEM and WB,
//                followed by hand-written sequences for reset, load-use,
//                jal/writeback, flush, external stall and counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctrl_pipeline;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0;
   logic [31:0] id_instr = '0;
   logic        flush = 1'b0;
   logic        stall_ext = 1'b0;
   logic        hazard_stall;
   logic        ex_valid, ex_alu_src, ex_sign_ext, ex_branch, ex_bne, ex_jump;
   logic [3:0]  ex_alu_op;
   logic [4:0]  ex_dest;
   logic        mem_valid, mem_read, mem_write;
   logic [4:0]  mem_dest;
   logic        wb_valid, wb_reg_write, wb_mem_to_reg, wb_link;
   logic [4:0]  wb_dest;
   logic [7:0]  illegal_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ctrl_pipeline #(.REG_AW(5), .ALUOP_W(4), .CNT_W(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_id_valid     (id_valid),
      .i_id_instr     (id_instr),
      .i_flush        (flush),
      .i_stall_ext    (stall_ext),
      .o_hazard_stall (hazard_stall),
      .o_ex_valid     (ex_valid),
      .o_ex_alu_src   (ex_alu_src),
      .o_ex_sign_ext  (ex_sign_ext),
      .o_ex_branch    (ex_branch),
      .o_ex_bne       (ex_bne),
      .o_ex_jump      (ex_jump),
      .o_ex_alu_op    (ex_alu_op),
      .o_ex_dest      (ex_dest),
      .o_mem_valid    (mem_valid),
      .o_mem_read     (mem_read),
      .o_mem_write    (mem_write),
      .o_mem_dest     (mem_dest),
      .o_wb_valid     (wb_valid),
      .o_wb_reg_write (wb_reg_write),
      .o_wb_mem_to_reg(wb_mem_to_reg),
      .o_wb_link      (wb_link),
      .o_wb_dest      (wb_dest),
      .o_illegal_cnt  (illegal_cnt)
   );

   typedef struct {
      logic        v;
      logic [31:0] instr;
      logic [5:0]  ctl;   // {ex_valid, alu_src, sign_ext, branch, bne, jump}
      logic [3:0]  aop;
      logic [4:0]  dst;
      logic [4:0]  mwb;   // {mem_read, mem_write, reg_write, mem_to_reg, link}
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(input logic v, input logic [31:0] instr,
                               input logic [5:0] ctl, input logic [3:0] aop,
                               input logic [4:0] dst, input logic [4:0] mwb);
      vec_t r;
      r.v = v; r.instr = instr; r.ctl = ctl; r.aop = aop; r.dst = dst; r.mwb = mwb;
      return r;
   endfunction

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd);
      return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt);
      return {op, rs, rt, 16'h0004};
   endfunction

   function automatic logic [31:0] jtype(input logic [5:0] op);
      return {op, 26'h0000010};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr,
                        input logic fl, input logic st);
      id_valid = v; id_instr = instr; flush = fl; stall_ext = st;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      tbl[0]  = mk(1, rtype(1, 2, 3),              6'b100000, 4'b1000, 5'd3,  5'b00100);
      tbl[1]  = mk(1, itype(6'b100011, 4, 5),      6'b110000, 4'b0000, 5'd5,  5'b10110);
      tbl[2]  = mk(1, itype(6'b101011, 6, 7),      6'b110000, 4'b0000, 5'd0,  5'b01000);
      tbl[3]  = mk(1, itype(6'b000100, 8, 9),      6'b100100, 4'b0100, 5'd0,  5'b00000);
      tbl[4]  = mk(1, itype(6'b000101, 1, 2),      6'b100110, 4'b0110, 5'd0,  5'b00000);
      tbl[5]  = mk(1, itype(6'b001000, 1, 10),     6'b111000, 4'b0001, 5'd10, 5'b00100);
      tbl[6]  = mk(1, itype(6'b001001, 1, 11),     6'b111000, 4'b0001, 5'd11, 5'b00100);
      tbl[7]  = mk(1, itype(6'b001100, 1, 12),     6'b110000, 4'b0010, 5'd12, 5'b00100);
      tbl[8]  = mk(1, itype(6'b001101, 1, 13),     6'b110000, 4'b0011, 5'd13, 5'b00100);
      tbl[9]  = mk(1, itype(6'b001110, 1, 14),     6'b110000, 4'b0101, 5'd14, 5'b00100);
      tbl[10] = mk(1, itype(6'b001111, 0, 15),     6'b110000, 4'b0111, 5'd15, 5'b00100);
      tbl[11] = mk(1, jtype(6'b000010),            6'b100001, 4'b0000, 5'd0,  5'b00000);
      tbl[12] = mk(1, jtype(6'b000011),            6'b100001, 4'b0000, 5'd31, 5'b00101);
      tbl[13] = mk(1, itype(6'b111111, 1, 2),      6'b000000, 4'b0000, 5'd0,  5'b00000);
      tbl[14] = mk(0, rtype(1, 2, 3),              6'b000000, 4'b0000, 5'd0,  5'b00000);
      tbl[15] = mk(1, rtype(1, 2, 0),              6'b100000, 4'b1000, 5'd0,  5'b00000);
      tbl[16] = mk(1, itype(6'b100011, 1, 0),      6'b110000, 4'b0000, 5'd0,  5'b10010);
      tbl[17] = mk(1, rtype(0, 0, 1),              6'b100000, 4'b1000, 5'd1,  5'b00100);

      // ---- reset state while rst_n is low
      #3;
      chk("reset_outputs", {ex_valid, ex_alu_src, ex_sign_ext, ex_branch, ex_bne, ex_jump,
                            ex_alu_op, ex_dest, mem_valid, mem_read, mem_write, mem_dest,
                            wb_valid, wb_reg_write, wb_mem_to_reg, wb_link, wb_dest}, 32'h0);
      chk("reset_cnt", {24'h0, illegal_cnt}, 32'h0);
      tick();
      rst_n = 1'b1;

      // ---- decode table, checked at every stage
      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].v, tbl[i].instr, 1'b0, 1'b0);
         #1;
         chk("tbl_hazard", {31'h0, hazard_stall}, 32'h0);
         tick();
         chk($sformatf("tbl_ex[%0d]", i),
             {ex_valid, ex_alu_src, ex_sign_ext, ex_branch, ex_bne, ex_jump, ex_alu_op, ex_dest},
             {tbl[i].ctl, tbl[i].aop, tbl[i].dst});
         if (i >= 1)
            chk($sformatf("tbl_mem[%0d]", i - 1), {mem_valid, mem_read, mem_write, mem_dest},
                {tbl[i-1].ctl[5], tbl[i-1].mwb[4:3], tbl[i-1].dst});
         if (i >= 2)
            chk($sformatf("tbl_wb[%0d]", i - 2),
                {wb_valid, wb_reg_write, wb_mem_to_reg, wb_link, wb_dest},
                {tbl[i-2].ctl[5], tbl[i-2].mwb[2:0], tbl[i-2].dst});
      end
      chk("tbl_illegal_cnt", {24'h0, illegal_cnt}, 32'd1);

      // ---- asynchronous reset mid-cycle with a busy pipeline
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {ex_valid, ex_dest, mem_valid, mem_dest, wb_valid, wb_dest,
                                  hazard_stall}, 32'h0);
      chk("async_reset_cnt", {24'h0, illegal_cnt}, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;

      // ---- load-use: lw $2,0($1); add $3,$2,$4
      drive(1'b1, itype(6'b100011, 1, 2), 1'b0, 1'b0);
      tick();
      drive(1'b1, rtype(2, 4, 3), 1'b0, 1'b0);
      #1;
      chk("lu_hazard_on", {31'h0, hazard_stall}, 32'h1);
      tick();
      chk("lu_bubble", {31'h0, ex_valid}, 32'h0);
      chk("lu_hazard_off", {31'h0, hazard_stall}, 32'h0);
      chk("lu_lw_in_mem", {mem_valid, mem_read, mem_dest}, {1'b1, 1'b1, 5'd2});
      tick();
      chk("lu_add_in_ex", {ex_valid, ex_alu_op, ex_dest}, {1'b1, 4'b1000, 5'd3});
      // rt of an I-type is a destination, not a source; rt of sw is a source
      drive(1'b1, itype(6'b100011, 1, 2), 1'b0, 1'b0);
      tick();
      drive(1'b1, itype(6'b001000, 9, 2), 1'b0, 1'b0);
      #1;
      chk("lu_addi_rt_no_hazard", {31'h0, hazard_stall}, 32'h0);
      drive(1'b1, itype(6'b101011, 9, 2), 1'b0, 1'b0);
      #1;
      chk("lu_sw_rt_hazard", {31'h0, hazard_stall}, 32'h1);
      drive(1'b0, itype(6'b101011, 9, 2), 1'b0, 1'b0);
      #1;
      chk("lu_invalid_no_hazard", {31'h0, hazard_stall}, 32'h0);
      tick();

      // ---- jal reaches WB after 3 edges; lw to $0 never writes
      drive(1'b1, jtype(6'b000011), 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      tick();
      chk("jal_wb", {wb_valid, wb_reg_write, wb_mem_to_reg, wb_link, wb_dest},
          {1'b1, 1'b1, 1'b0, 1'b1, 5'd31});
      drive(1'b1, itype(6'b100011, 1, 0), 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      tick();
      chk("lw_r0_wb", {wb_valid, wb_reg_write, wb_mem_to_reg, wb_link, wb_dest},
          {1'b1, 1'b0, 1'b1, 1'b0, 5'd0});

      // ---- flush kills beq in ID; older instructions advance
      drive(1'b1, itype(6'b001000, 1, 10), 1'b0, 1'b0);
      tick();
      drive(1'b1, itype(6'b001101, 1, 13), 1'b0, 1'b0);
      tick();
      drive(1'b1, itype(6'b000100, 8, 9), 1'b1, 1'b0);
      tick();
      chk("flush_ex", {31'h0, ex_valid}, 32'h0);
      chk("flush_mem", {mem_valid, mem_dest}, {1'b1, 5'd13});
      chk("flush_wb", {wb_valid, wb_reg_write, wb_dest}, {1'b1, 1'b1, 5'd10});

      // ---- external stall over a pending load-use hazard
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick(); tick(); tick();
      drive(1'b1, itype(6'b100011, 1, 2), 1'b0, 1'b0);
      tick();
      drive(1'b1, rtype(2, 4, 3), 1'b0, 1'b1);
      #1;
      chk("stall_hazard_pre", {31'h0, hazard_stall}, 32'h1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_ex_hold",
             {ex_valid, ex_alu_src, ex_sign_ext, ex_branch, ex_bne, ex_jump, ex_alu_op, ex_dest},
             {6'b110000, 4'b0000, 5'd2});
         chk("stall_mem_wb_hold", {mem_valid, wb_valid}, 32'h0);
         chk("stall_hazard_held", {31'h0, hazard_stall}, 32'h1);
      end
      stall_ext = 1'b0;
      tick();
      chk("stall_release_bubble", {31'h0, ex_valid}, 32'h0);
      chk("stall_release_mem", {mem_valid, mem_read, mem_write, mem_dest},
          {1'b1, 1'b1, 1'b0, 5'd2});
      tick();
      chk("stall_add_ex", {ex_valid, ex_alu_op, ex_dest}, {1'b1, 4'b1000, 5'd3});
      chk("stall_lw_wb", {wb_valid, wb_reg_write, wb_mem_to_reg, wb_dest},
          {1'b1, 1'b1, 1'b1, 5'd2});

      // ---- illegal opcode counting and saturation
      do_reset();
      drive(1'b1, itype(6'b111111, 1, 2), 1'b0, 1'b1);
      tick();
      chk("cnt_stall_hold", {24'h0, illegal_cnt}, 32'd0);
      drive(1'b1, itype(6'b111111, 1, 2), 1'b1, 1'b0);
      tick();
      chk("cnt_flush_hold", {24'h0, illegal_cnt}, 32'd0);
      drive(1'b1, itype(6'b111111, 1, 2), 1'b0, 1'b0);
      for (int n = 1; n <= 300; n++) begin
         tick();
         chk("illegal_wb_bubble", {31'h0, wb_valid}, 32'h0);
         if (n == 254) chk("cnt_254", {24'h0, illegal_cnt}, 32'd254);
         if (n == 255) chk("cnt_255", {24'h0, illegal_cnt}, 32'd255);
      end
      chk("cnt_saturated", {24'h0, illegal_cnt}, 32'd255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
